// File: rtl/rf_wb_arbiter.sv
// Two-requester writeback arbiter for the register file. It alternates priority under
// contention, tracks outstanding destination registers and counts cycles lost to arbitration.
module rf_wb_arbiter #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              rf_write,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_data,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic [31:0]       pending,
  output logic [15:0]       stall_cnt
);

  // prio_reg == 0 means requester 0 wins the next contended cycle
  logic              prio_reg, prio_next;
  logic              rf_write_reg, rf_write_next;
  logic [ADDR_W-1:0] rf_addr_reg, rf_addr_next;
  logic [DATA_W-1:0] rf_data_reg, rf_data_next;
  logic [31:0]       pending_reg, pending_next;
  logic [15:0]       stall_reg, stall_next;

  logic              grant0, grant1, handshake, stall_event;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;
  logic [31:0]       set_vec, clr_vec;

  always_comb begin
    grant0      = !rst && req0_valid && (!req1_valid || !prio_reg);
    grant1      = !rst && req1_valid && (!req0_valid ||  prio_reg);
    handshake   = grant0 || grant1;
    win_addr    = grant1 ? req1_addr : req0_addr;
    win_data    = grant1 ? req1_data : req0_data;
    stall_event = (req0_valid && !grant0) || (req1_valid && !grant1);
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Register 0 is hardwired to zero, so it is never tracked as outstanding.
  assign set_vec[0] = 1'b0;
  assign clr_vec[0] = 1'b0;

  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_pending
      assign set_vec[gi] = issue_valid && (issue_rd == ADDR_W'(gi));
      assign clr_vec[gi] = handshake   && (win_addr == ADDR_W'(gi));
    end
  endgenerate

  always_comb begin
    prio_next     = prio_reg;
    rf_write_next = 1'b0;
    rf_addr_next  = rf_addr_reg;
    rf_data_next  = rf_data_reg;
    stall_next    = stall_reg;

    if (handshake && req0_valid && req1_valid)
      prio_next = ~prio_reg;

    // Writes to x0 still complete the handshake but never reach the register file.
    if (handshake && (win_addr != '0)) begin
      rf_write_next = 1'b1;
      rf_addr_next  = win_addr;
      rf_data_next  = win_data;
    end

    // A new issue to the same register outranks the retiring write.
    pending_next = (pending_reg & ~clr_vec) | set_vec;

    if (stall_event && (stall_reg != 16'hFFFF))
      stall_next = stall_reg + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_reg     <= 1'b0;
      rf_write_reg <= 1'b0;
      rf_addr_reg  <= '0;
      rf_data_reg  <= '0;
      pending_reg  <= '0;
      stall_reg    <= '0;
    end else begin
      prio_reg     <= prio_next;
      rf_write_reg <= rf_write_next;
      rf_addr_reg  <= rf_addr_next;
      rf_data_reg  <= rf_data_next;
      pending_reg  <= pending_next;
      stall_reg    <= stall_next;
    end
  end

  assign rf_write  = rf_write_reg;
  assign rf_addr   = rf_addr_reg;
  assign rf_data   = rf_data_reg;
  assign pending   = pending_reg;
  assign stall_cnt = stall_reg;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: the stimulus pushes expected register-file writes into a
// queue and an independent monitor pops and compares them whenever rf_write is seen.
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [4:0]  req0_addr, req1_addr, rf_addr, issue_rd;
  logic [63:0] req0_data, req1_data, rf_data;
  logic        rf_write, issue_valid;
  logic [31:0] pending;
  logic [15:0] stall_cnt;

  typedef struct {
    int          cyc;
    logic [4:0]  addr;
    logic [63:0] data;
  } wr_t;

  wr_t sb[$];
  int  errors = 0;
  int  checks = 0;
  int  cyc    = 0;

  rf_wb_arbiter #(.DATA_W(64), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
    .rf_write(rf_write), .rf_addr(rf_addr), .rf_data(rf_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .pending(pending), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else
      $display("ok   %s: %0h", name, act);
  endtask

  // Monitor: every presented write must match the oldest expected one, in the expected cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (rf_write) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL spurious_write: got addr=%0d data=%0h expected no write", rf_addr, rf_data);
        end else begin
          wr_t e;
          e = sb.pop_front();
          if (e.cyc != cyc || rf_addr !== e.addr || rf_data !== e.data) begin
            errors++;
            $display("FAIL rf_write: got cyc=%0d addr=%0d data=%0h expected cyc=%0d addr=%0d data=%0h",
                     cyc, rf_addr, rf_data, e.cyc, e.addr, e.data);
          end else
            $display("ok   rf_write: cyc=%0d addr=%0d data=%0h", cyc, rf_addr, rf_data);
        end
      end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        wr_t e;
        e = sb.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_write: got none expected addr=%0d data=%0h at cyc=%0d", e.addr, e.data, e.cyc);
      end
    end
  end

  // One cycle of stimulus: apply at the falling edge, check the readies, queue the expected write.
  task automatic drive(input string name,
                       input logic v0, input logic [4:0] a0, input logic [63:0] d0,
                       input logic v1, input logic [4:0] a1, input logic [63:0] d1,
                       input logic iv, input logic [4:0] ird,
                       input logic eg0, input logic eg1);
    wr_t e;
    @(negedge clk);
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    issue_valid = iv; issue_rd = ird;
    #1;
    chk({name, "_ready0"}, {63'd0, req0_ready}, {63'd0, eg0});
    chk({name, "_ready1"}, {63'd0, req1_ready}, {63'd0, eg1});
    if (!rst && eg0 && a0 != 5'd0) begin
      e.cyc = cyc + 1; e.addr = a0; e.data = d0; sb.push_back(e);
    end
    if (!rst && eg1 && a1 != 5'd0) begin
      e.cyc = cyc + 1; e.addr = a1; e.data = d1; sb.push_back(e);
    end
  endtask

  task automatic idle(input string name);
    drive(name, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 0; req0_addr = 0; req0_data = 0;
    req1_valid = 0; req1_addr = 0; req1_data = 0;
    issue_valid = 0; issue_rd = 0;
    #1;
    chk("reset_rf_write", {63'd0, rf_write}, 64'd0);
    chk("reset_pending", {32'd0, pending}, 64'd0);
    chk("reset_stall", {48'd0, stall_cnt}, 64'd0);
    #1 rst = 1'b0;

    // Continuous contention: grants alternate 0,1,0,1
    drive("cont0", 1, 5'd1, 64'h11, 1, 5'd2, 64'h22, 0, 5'd0, 1, 0);
    drive("cont1", 1, 5'd1, 64'h13, 1, 5'd2, 64'h24, 0, 5'd0, 0, 1);
    drive("cont2", 1, 5'd1, 64'h15, 1, 5'd2, 64'h26, 0, 5'd0, 1, 0);
    drive("cont3", 1, 5'd1, 64'h17, 1, 5'd2, 64'h28, 0, 5'd0, 0, 1);
    idle("idle0");
    chk("stall_after_cont", {48'd0, stall_cnt}, 64'd4);

    // Single requester
    drive("single", 1, 5'd5, 64'hDEAD, 0, 5'd0, 64'd0, 0, 5'd0, 1, 0);
    idle("idle1");
    idle("idle2");
    chk("stall_single", {48'd0, stall_cnt}, 64'd4);

    // x0 write completes but is discarded; rf_addr/rf_data hold
    drive("x0", 0, 5'd0, 64'd0, 1, 5'd0, 64'hFF, 0, 5'd0, 0, 1);
    idle("idle3");
    #1;
    chk("x0_hold_addr", {59'd0, rf_addr}, 64'd5);
    chk("x0_hold_data", rf_data, 64'hDEAD);
    chk("x0_no_write", {63'd0, rf_write}, 64'd0);

    // Scoreboard set then clear
    drive("issue7", 0, 5'd0, 64'd0, 0, 5'd0, 64'd0, 1, 5'd7, 0, 0);
    settle();
    chk("pending_set7", {32'd0, pending}, 64'h80);
    idle("idle4");
    idle("idle5");
    drive("wr7", 1, 5'd7, 64'h77, 0, 5'd0, 64'd0, 0, 5'd0, 1, 0);
    settle();
    chk("pending_clr7", {32'd0, pending}, 64'h0);
    // Same-edge set and clear: the set wins; an issue to x0 is ignored
    drive("setclr7", 0, 5'd0, 64'd0, 1, 5'd7, 64'h78, 1, 5'd7, 0, 1);
    settle();
    chk("pending_setwins", {32'd0, pending}, 64'h80);
    drive("issue0", 0, 5'd0, 64'd0, 0, 5'd0, 64'd0, 1, 5'd0, 0, 0);
    settle();
    chk("pending_x0", {32'd0, pending}, 64'h80);

    // Reset mid-operation: the handshaken addr=9 write must be dropped
    drive("pre_rst", 1, 5'd9, 64'h99, 1, 5'd2, 64'h2A, 0, 5'd0, 1, 0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    chk("async_rf_write", {63'd0, rf_write}, 64'd0);
    chk("async_rf_addr", {59'd0, rf_addr}, 64'd0);
    chk("async_pending", {32'd0, pending}, 64'd0);
    chk("async_stall", {48'd0, stall_cnt}, 64'd0);
    drive("in_rst", 1, 5'd3, 64'h33, 1, 5'd4, 64'h44, 0, 5'd0, 0, 0);
    settle();
    chk("in_rst_no_write", {63'd0, rf_write}, 64'd0);
    #1 rst = 1'b0;
    // Priority was flipped to requester 1 before reset; it must be back at requester 0
    drive("post_rst", 1, 5'd3, 64'h33, 1, 5'd4, 64'h44, 0, 5'd0, 1, 0);
    settle();
    chk("post_rst_stall", {48'd0, stall_cnt}, 64'd1);

    // Saturation under sustained contention (x0 targets so no writes are produced)
    req0_addr = 5'd0;
    req1_addr = 5'd0;
    repeat (1000) @(posedge clk);
    #1;
    chk("stall_1001", {48'd0, stall_cnt}, 64'd1001);
    repeat (69000) @(posedge clk);
    #1;
    chk("stall_sat", {48'd0, stall_cnt}, 64'hFFFF);
    @(posedge clk);
    #1;
    chk("stall_sat_hold", {48'd0, stall_cnt}, 64'hFFFF);

    idle("idle_end");
    idle("idle_end2");
    chk("queue_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64, meaning the writeback data width.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning the register address width (32 registers).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1: reset is asynchronous and active-high.
REQ-005 The block SHALL have ports req0_valid, input, 1, and req0_ready, output, 1: the requester-0 (ALU writeback) handshake.
REQ-006 The block SHALL have ports req0_addr, input, ADDR_W, and req0_data, input, DATA_W: the requester-0 destination register and value.
REQ-007 The block SHALL have ports req1_valid, input, 1, req1_ready, output, 1, req1_addr, input, ADDR_W, and req1_data, input, DATA_W: the same handshake for requester 1 (load/mul-div writeback).
REQ-008 The block SHALL have ports rf_write, output, 1, rf_addr, output, ADDR_W, and rf_data, output, DATA_W: the registered drive of the register-file write port.
REQ-009 The block SHALL have ports issue_valid, input, 1, and issue_rd, input, ADDR_W: the decode-stage notice that an instruction targeting issue_rd has issued.
REQ-010 The block SHALL have port pending, output, 32: a per-register outstanding-write scoreboard.
REQ-011 The block SHALL have port stall_cnt, output, 16: a saturating count of cycles in which any valid requester was not granted.

Function
REQ-012 The block SHALL form a handshake on reqN at a rising edge where reqN_valid and reqN_ready are both 1.
REQ-013 The block SHALL derive reqN_ready combinationally, SHALL assert it only while reqN_valid is 1, and SHALL assert at most one ready in any cycle.
REQ-014 When only one requester is valid, the block SHALL grant that requester.
REQ-015 When both requesters are valid, the block SHALL grant the requester holding priority; the priority flop SHALL then pass to the other requester, so grants alternate 0,1,0,1 under continuous contention.
REQ-016 The priority flop SHALL change only on a handshake, and only when both requesters were valid in that cycle.
REQ-017 The cycle after a handshake with addr != 0, the block SHALL set rf_write=1 and drive rf_addr and rf_data with the granted requester's values; latency is exactly 1 cycle.
REQ-018 rf_write SHALL be 1 for exactly one cycle per handshake; with no handshake, rf_write SHALL be 0 next cycle and rf_addr/rf_data SHALL hold their prior values.
REQ-019 A handshake with addr == 0 SHALL complete normally, but rf_write SHALL remain 0 next cycle (x0 writes are discarded).
REQ-020 issue_valid=1 with issue_rd != 0 SHALL set pending[issue_rd] at the next edge.
REQ-021 A handshake SHALL clear pending[addr] at the same edge.
REQ-022 When a set and a clear target the same register at the same edge, the set SHALL win and the bit SHALL end at 1.
REQ-023 pending[0] SHALL be constant 0.
REQ-024 stall_cnt SHALL increment by 1 at each edge where some reqN_valid=1 and reqN_ready=0, and SHALL saturate at 0xFFFF.
REQ-025 The block SHALL have no backpressure from the register file: exactly one handshake SHALL occur in every cycle in which any requester is valid.

Reset
REQ-026 Asserting rst SHALL immediately set rf_write=0, rf_addr=0, rf_data=0, pending=0, stall_cnt=0, and priority to requester 0, regardless of clock.
REQ-027 A write registered but not yet presented when rst asserts SHALL be dropped.
REQ-028 While rst=1, no handshake SHALL occur (both readies 0).
REQ-029 The first edge after rst deasserts SHALL process requests normally.

Verification
REQ-030 Single requester: req0 valid, addr=5, data=0xDEAD for 1 cycle -> req0_ready=1 that cycle; next cycle rf_write=1, rf_addr=5, rf_data=0xDEAD; following cycle rf_write=0.
REQ-031 Contention: both valid for 4 cycles after reset, req0 addr=1, req1 addr=2 -> grants 0,1,0,1; rf_addr sequence 1,2,1,2; stall_cnt=4.
REQ-032 x0 write: req1 valid, addr=0, data=0xFF -> req1_ready=1; rf_write stays 0.
REQ-033 Scoreboard: issue rd=7, then 3 cycles later req0 writes addr 7 -> pending[7] rises after the issue edge and falls after the write edge; with issue rd=7 and a write to 7 in the same cycle -> pending[7] remains 1.
REQ-034 Reset mid-operation: handshake on addr=9, then rst asserted asynchronously before the next edge -> rf_write=0 at once; pending=0; priority back at requester 0.
REQ-035 Saturation: req0 and req1 held valid for 70000 cycles -> stall_cnt stops at 0xFFFF.
